// File: rtl/bilinear_fetch_interp_pkg.sv
// Shared types and helpers for the bilinear fetch/interpolate block.
// Holds the FSM state type, default geometry and the coordinate clamp rule.
package bilineal_pkg;

    localparam int unsigned DEF_IMG_W   = 64;
    localparam int unsigned DEF_IMG_H   = 64;
    localparam int unsigned DEF_FRAC_W  = 8;
    localparam int unsigned DEF_COORD_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_F0,
        ST_F1,
        ST_F2,
        ST_F3,
        ST_CAP,
        ST_CALC,
        ST_OUT
    } bl_state_e;

    typedef struct packed {
        logic [31:0] idx0;
        logic [31:0] idx1;
        logic        frac_zero;
    } clamp_t;

    // Coordinates at or past the last row/column pin to it and drop the fraction.
    function automatic clamp_t clamp_coord(input logic [31:0] int_part,
                                           input logic [31:0] limit);
        clamp_t r;
        r.frac_zero = (int_part >= limit - 32'd1);
        r.idx0      = r.frac_zero ? (limit - 32'd1) : int_part;
        r.idx1      = ((r.idx0 + 32'd1) >= limit) ? (limit - 32'd1) : (r.idx0 + 32'd1);
        return r;
    endfunction

endpackage

// File: rtl/bilinear_fetch_interp_lerp_dp.sv
// Combinational bilinear blend of four 8-bit pixels with round-half-up.
// Weights are S-f and f with S = 2^FRAC_W; the result always fits in 8 bits.
module bilinear_lerp_dp
    import bilineal_pkg::*;
#(
    parameter int unsigned FRAC_W = DEF_FRAC_W
) (
    input  logic [7:0]        p00_i,
    input  logic [7:0]        p01_i,
    input  logic [7:0]        p10_i,
    input  logic [7:0]        p11_i,
    input  logic [FRAC_W-1:0] fx_i,
    input  logic [FRAC_W-1:0] fy_i,
    output logic [7:0]        pix_o
);

    localparam int unsigned TW = 8 + FRAC_W + 1;
    localparam int unsigned AW = TW + FRAC_W + 1;

    localparam logic [FRAC_W:0] S    = {1'b1, {FRAC_W{1'b0}}};
    localparam logic [AW-1:0]   HALF = {{(AW - 2*FRAC_W){1'b0}}, 1'b1, {(2*FRAC_W - 1){1'b0}}};

    logic [FRAC_W:0] wx0, wx1, wy0, wy1;
    logic [TW-1:0]   top, bot;
    logic [AW-1:0]   acc;
    logic            unused_acc_bits;

    always_comb begin
        wx0 = {1'b0, fx_i};
        wx1 = S - wx0;
        wy0 = {1'b0, fy_i};
        wy1 = S - wy0;
        top = TW'(p00_i) * TW'(wx1) + TW'(p01_i) * TW'(wx0);
        bot = TW'(p10_i) * TW'(wx1) + TW'(p11_i) * TW'(wx0);
        acc = AW'(top) * AW'(wy1) + AW'(bot) * AW'(wy0) + HALF;
    end

    assign pix_o           = acc[2*FRAC_W +: 8];
    assign unused_acc_bits = ^{acc[AW-1:2*FRAC_W+8], acc[2*FRAC_W-1:0]};

endmodule

// File: rtl/bilinear_fetch_interp.sv
// Sequential bilinear sampler: fetches four neighbours over one 1-cycle-latency
// RAM read port, blends them, and presents one pixel on a valid/ready output.
module bilinear_fetch_interp
    import bilineal_pkg::*;
#(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned IMG_W   = DEF_IMG_W,
    parameter int unsigned IMG_H   = DEF_IMG_H,
    parameter int unsigned FRAC_W  = DEF_FRAC_W,
    parameter int unsigned COORD_W = DEF_COORD_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [COORD_W-1:0] req_x,
    input  logic [COORD_W-1:0] req_y,
    output logic [ADDR_W-1:0]  raddr,
    input  logic [7:0]         rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_pix,
    output logic               busy
);

    localparam int unsigned XW = $clog2(IMG_W);
    localparam int unsigned YW = $clog2(IMG_H);

    bl_state_e         state_q, state_d;
    logic [XW-1:0]     x0_q, x1_q;
    logic [YW-1:0]     y0_q, y1_q;
    logic [FRAC_W-1:0] fx_q, fy_q;
    logic [7:0]        p00_q, p01_q, p10_q, p11_q;
    logic [7:0]        out_pix_q;
    logic [7:0]        lerp_pix;

    clamp_t            cx, cy;
    logic              unused_clamp_hi;
    logic [ADDR_W-1:0] a00, a01, a10, a11;

    assign cx = clamp_coord(32'(req_x >> FRAC_W), 32'(IMG_W));
    assign cy = clamp_coord(32'(req_y >> FRAC_W), 32'(IMG_H));
    assign unused_clamp_hi = ^{cx.idx0[31:XW], cx.idx1[31:XW], cy.idx0[31:YW], cy.idx1[31:YW]};

    // Row-major address as a plain concatenation since both dimensions are powers of two.
    assign a00 = ADDR_W'({y0_q, x0_q});
    assign a01 = ADDR_W'({y0_q, x1_q});
    assign a10 = ADDR_W'({y1_q, x0_q});
    assign a11 = ADDR_W'({y1_q, x1_q});

    bilinear_lerp_dp #(
        .FRAC_W(FRAC_W)
    ) u_lerp (
        .p00_i(p00_q),
        .p01_i(p01_q),
        .p10_i(p10_q),
        .p11_i(p11_q),
        .fx_i (fx_q),
        .fy_i (fy_q),
        .pix_o(lerp_pix)
    );

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        raddr     = '0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) state_d = ST_F0;
            end
            ST_F0: begin
                raddr   = a00;
                state_d = ST_F1;
            end
            ST_F1: begin
                raddr   = a01;
                state_d = ST_F2;
            end
            ST_F2: begin
                raddr   = a10;
                state_d = ST_F3;
            end
            ST_F3: begin
                raddr   = a11;
                state_d = ST_CAP;
            end
            ST_CAP: begin
                raddr   = a11;
                state_d = ST_CALC;
            end
            ST_CALC: begin
                state_d = ST_OUT;
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Each fetch state captures the data for the address presented one state earlier.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            x0_q      <= '0;
            x1_q      <= '0;
            y0_q      <= '0;
            y1_q      <= '0;
            fx_q      <= '0;
            fy_q      <= '0;
            p00_q     <= '0;
            p01_q     <= '0;
            p10_q     <= '0;
            p11_q     <= '0;
            out_pix_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        x0_q <= cx.idx0[XW-1:0];
                        x1_q <= cx.idx1[XW-1:0];
                        y0_q <= cy.idx0[YW-1:0];
                        y1_q <= cy.idx1[YW-1:0];
                        fx_q <= cx.frac_zero ? '0 : req_x[FRAC_W-1:0];
                        fy_q <= cy.frac_zero ? '0 : req_y[FRAC_W-1:0];
                    end
                end
                ST_F1:   p00_q     <= rdata;
                ST_F2:   p01_q     <= rdata;
                ST_F3:   p10_q     <= rdata;
                ST_CAP:  p11_q     <= rdata;
                ST_CALC: out_pix_q <= lerp_pix;
                default: ;
            endcase
        end
    end

    assign out_pix = out_pix_q;

endmodule

// File: tb/tb_bilinear_fetch_interp.sv
// Scoreboard bench for bilinear_fetch_interp with a 1-cycle-latency RAM model.
module tb_bilinear_fetch_interp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_x = '0;
    logic [15:0] req_y = '0;
    logic [11:0] raddr;
    logic [7:0]  rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_pix;
    logic        busy;

    logic [7:0]  mem [0:4095];
    logic [7:0]  exp_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          acc_cyc  = 0;
    int          hs_cyc   = 0;

    bilinear_fetch_interp #(
        .ADDR_W (12),
        .IMG_W  (64),
        .IMG_H  (64),
        .FRAC_W (8),
        .COORD_W(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_x    (req_x),
        .req_y    (req_y),
        .raddr    (raddr),
        .rdata    (rdata),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pix  (out_pix),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rdata <= mem[raddr];
        cyc   <= cyc + 1;
        if (!rst && req_valid && req_ready) acc_cyc <= cyc;
        if (!rst && out_valid && out_ready) hs_cyc  <= cyc;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Reference model: clamp, then weight the four corners directly.
    function automatic int lo_idx(input int c, input int lim);
        return (c >= lim - 1) ? lim - 1 : c;
    endfunction

    function automatic int hi_idx(input int c, input int lim);
        int i = lo_idx(c, lim);
        return (i + 1 > lim - 1) ? lim - 1 : i + 1;
    endfunction

    function automatic int frac_of(input logic [15:0] v);
        return (int'(v[15:8]) >= 63) ? 0 : int'(v[7:0]);
    endfunction

    function automatic logic [11:0] model_addr(input logic [15:0] x, input logic [15:0] y, input int k);
        int xs = (k % 2 == 1) ? hi_idx(int'(x[15:8]), 64) : lo_idx(int'(x[15:8]), 64);
        int ys = (k >= 2)     ? hi_idx(int'(y[15:8]), 64) : lo_idx(int'(y[15:8]), 64);
        return 12'(ys * 64 + xs);
    endfunction

    function automatic logic [7:0] model_pix(input logic [15:0] x, input logic [15:0] y);
        longint fx  = longint'(frac_of(x));
        longint fy  = longint'(frac_of(y));
        longint p00 = longint'(mem[model_addr(x, y, 0)]);
        longint p01 = longint'(mem[model_addr(x, y, 1)]);
        longint p10 = longint'(mem[model_addr(x, y, 2)]);
        longint p11 = longint'(mem[model_addr(x, y, 3)]);
        longint num = p00 * (256 - fx) * (256 - fy) + p01 * fx * (256 - fy)
                    + p10 * (256 - fx) * fy + p11 * fx * fy;
        return 8'((num + 32768) / 65536);
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("spurious_out", 1, 0);
            else check("out_pix", out_pix, exp_q.pop_front());
        end
    end

    // Called at a negedge; returns at the negedge where OUT is first visible,
    // or right after a reset pulse when rst_at names a post-accept cycle.
    task automatic run_req(input logic [15:0] x, input logic [15:0] y,
                           input logic [7:0] exp_pix, input int rst_at);
        int waited = 0;
        exp_q.push_back(exp_pix);
        req_x     = x;
        req_y     = y;
        req_valid = 1'b1;
        while (!req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            check("accept_timeout", 0, 1);
            void'(exp_q.pop_back());
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) check("busy", busy, 1);
            if (k <= 4) check("raddr_seq", raddr, model_addr(x, y, k - 1));
            if (k == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                check("rst_out_valid", out_valid, 0);
                check("rst_req_ready", req_ready, 1);
                check("rst_raddr", raddr, 0);
                check("rst_busy", busy, 0);
                rst = 1'b0;
                void'(exp_q.pop_back());
                return;
            end
            if (k == 6) check("lat_early", out_valid, 0);
            if (k == 7) check("lat_valid", out_valid, 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  expb;
        logic [15:0] xr, yr;

        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom_range(0, 255));
        mem[330] = 8'd100;
        mem[194] = 8'd0;   mem[195] = 8'd100; mem[258] = 8'd100; mem[259] = 8'd200;
        mem[660] = 8'd0;   mem[661] = 8'd255; mem[724] = 8'd0;   mem[725] = 8'd255;
        mem[63]  = 8'd77;

        repeat (3) @(negedge clk);
        check("reset_req_ready", req_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_pix", out_pix, 0);
        check("reset_raddr", raddr, 0);
        check("reset_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);

        run_req(16'h0A00, 16'h0500, 8'd100, 0);
        run_req(16'h0280, 16'h0380, 8'd100, 0);
        run_req(16'h1440, 16'h0A00, 8'd64, 0);
        run_req(16'h3F80, 16'h0000, 8'd77, 0);
        run_req(16'h5000, 16'h0000, 8'd77, 0);

        @(negedge clk);
        out_ready = 1'b0;
        expb = model_pix(16'h1234, 16'h2180);
        run_req(16'h1234, 16'h2180, expb, 0);
        req_x     = 16'h0710;
        req_y     = 16'h09C0;
        req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check("bp_out_valid", out_valid, 1);
            check("bp_out_pix", out_pix, expb);
            check("bp_req_ready", req_ready, 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        run_req(16'h0710, 16'h09C0, model_pix(16'h0710, 16'h09C0), 0);
        check("accept_after_hs", acc_cyc, hs_cyc + 1);

        @(negedge clk);
        run_req(16'h0A80, 16'h0B40, model_pix(16'h0A80, 16'h0B40), 3);
        @(negedge clk);
        run_req(16'h0C40, 16'h0D20, model_pix(16'h0C40, 16'h0D20), 0);

        for (int i = 0; i < 10; i++) begin
            xr = 16'($urandom_range(0, 16'h4400));
            yr = 16'($urandom_range(0, 16'h4400));
            run_req(xr, yr, model_pix(xr, yr), 0);
        end

        repeat (10) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
